// File: rtl/knn_sched_if.sv
// Memory and distance-core side of the KNN scheduler.
// The master modport is the scheduler; the slave modport is the memory/core side.
interface knn_sched_if #(
  parameter int COORD_W = 16,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 10
);
  logic                   mem_en;
  logic [IDX_W-1:0]       mem_addr;
  logic [2*COORD_W-1:0]   mem_rdata;
  logic                   core_rst;
  logic                   core_en;
  logic [2*COORD_W-1:0]   core_a;
  logic [2*COORD_W-1:0]   core_b;
  logic [DATA_W-1:0]      core_dist;

  modport master (
    output mem_en, mem_addr, core_rst, core_en, core_a, core_b,
    input  mem_rdata, core_dist
  );

  modport slave (
    input  mem_en, mem_addr, core_rst, core_en, core_a, core_b,
    output mem_rdata, core_dist
  );
endinterface

// File: rtl/knn_sched.sv
// K-nearest-neighbour sequencer: walks N training points through the distance
// core and keeps a sorted top-K list (slot 0 nearest, ties keep the lower index).
module knn_sched #(
  parameter int COORD_W  = 16,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 10,
  parameter int K        = 4,
  parameter int DIST_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IDX_W-1:0]      n_points,
  input  logic [2*COORD_W-1:0]  test_pt,
  output logic                  busy,
  output logic                  done,
  output logic [K*IDX_W-1:0]    nn_idx,
  output logic [K*DATA_W-1:0]   nn_dist,
  output logic [K-1:0]          nn_valid,
  knn_sched_if.master           bus
);

  localparam int WCNT_W = (DIST_LAT > 1) ? $clog2(DIST_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DIST   = 3'd2,
    WAIT   = 3'd3,
    INSERT = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t               state_r, state_next_s;
  logic [IDX_W-1:0]     i_r, npts_r, i_inc_s;
  logic [2*COORD_W-1:0] test_r, core_b_r;
  logic [WCNT_W-1:0]    wait_cnt_r;
  logic                 busy_r, done_r, mem_en_r, core_rst_r, core_en_r;
  logic [IDX_W-1:0]     idx_r   [K];
  logic [DATA_W-1:0]    dist_r  [K];
  logic [K-1:0]         valid_r;
  logic [IDX_W-1:0]     idx_nx_s  [K];
  logic [DATA_W-1:0]    dist_nx_s [K];
  logic [K-1:0]         valid_nx_s;
  logic [K-1:0]         le_s;

  assign i_inc_s = i_r + IDX_W'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (n_points == {IDX_W{1'b0}}) ? DONE : FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH:  state_next_s = DIST;
      DIST:   state_next_s = WAIT;
      WAIT: begin
        if (wait_cnt_r == {WCNT_W{1'b0}}) begin
          state_next_s = INSERT;
        end else begin
          state_next_s = WAIT;
        end
      end
      INSERT: begin
        if (i_inc_s == npts_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = FETCH;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Sorted insert: the list is always valid-prefix and ascending, so a slot keeps
  // its entry while it is <= the new distance, takes the new entry at the first
  // slot that is not, and inherits its upper neighbour after that.
  always_comb begin
    for (int j = 0; j < K; j++) begin
      le_s[j] = valid_r[j] && (dist_r[j] <= bus.core_dist);
    end
    if (le_s[0]) begin
      idx_nx_s[0]   = idx_r[0];
      dist_nx_s[0]  = dist_r[0];
      valid_nx_s[0] = valid_r[0];
    end else begin
      idx_nx_s[0]   = i_r;
      dist_nx_s[0]  = bus.core_dist;
      valid_nx_s[0] = 1'b1;
    end
    for (int j = 1; j < K; j++) begin
      if (le_s[j]) begin
        idx_nx_s[j]   = idx_r[j];
        dist_nx_s[j]  = dist_r[j];
        valid_nx_s[j] = valid_r[j];
      end else if (le_s[j-1]) begin
        idx_nx_s[j]   = i_r;
        dist_nx_s[j]  = bus.core_dist;
        valid_nx_s[j] = 1'b1;
      end else begin
        idx_nx_s[j]   = idx_r[j-1];
        dist_nx_s[j]  = dist_r[j-1];
        valid_nx_s[j] = valid_r[j-1];
      end
    end
  end

  // Datapath, list storage and registered control outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      i_r        <= {IDX_W{1'b0}};
      npts_r     <= {IDX_W{1'b0}};
      test_r     <= {(2*COORD_W){1'b0}};
      core_b_r   <= {(2*COORD_W){1'b0}};
      wait_cnt_r <= {WCNT_W{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      mem_en_r   <= 1'b0;
      core_rst_r <= 1'b0;
      core_en_r  <= 1'b0;
      valid_r    <= {K{1'b0}};
      for (int j = 0; j < K; j++) begin
        idx_r[j]  <= {IDX_W{1'b0}};
        dist_r[j] <= {DATA_W{1'b0}};
      end
    end else begin
      busy_r     <= (state_next_s != IDLE);
      done_r     <= (state_next_s == DONE);
      mem_en_r   <= (state_next_s == FETCH);
      core_rst_r <= (state_next_s == FETCH);
      core_en_r  <= (state_next_s == DIST);
      case (state_r)
        IDLE: begin
          if (start) begin
            npts_r  <= n_points;
            test_r  <= test_pt;
            i_r     <= {IDX_W{1'b0}};
            valid_r <= {K{1'b0}};
          end
        end
        DIST: begin
          core_b_r   <= bus.mem_rdata;
          wait_cnt_r <= WCNT_W'(DIST_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt_r != {WCNT_W{1'b0}}) begin
            wait_cnt_r <= wait_cnt_r - WCNT_W'(1);
          end
        end
        INSERT: begin
          for (int j = 0; j < K; j++) begin
            idx_r[j]  <= idx_nx_s[j];
            dist_r[j] <= dist_nx_s[j];
          end
          valid_r <= valid_nx_s;
          i_r     <= i_inc_s;
        end
        default: begin
        end
      endcase
    end
  end

  // Result packing, slot 0 at the LSBs
  always_comb begin
    nn_idx  = {(K*IDX_W){1'b0}};
    nn_dist = {(K*DATA_W){1'b0}};
    for (int j = 0; j < K; j++) begin
      nn_idx[j*IDX_W +: IDX_W]   = idx_r[j];
      nn_dist[j*DATA_W +: DATA_W] = dist_r[j];
    end
  end

  assign nn_valid     = valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign bus.mem_en   = mem_en_r;
  assign bus.mem_addr = i_r;
  assign bus.core_rst = core_rst_r;
  assign bus.core_en  = core_en_r;
  assign bus.core_a   = test_r;
  // mem_rdata lands during DIST, so core_b passes it straight through then
  assign bus.core_b   = (state_r == DIST) ? bus.mem_rdata : core_b_r;

endmodule
